// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes, FSM states, error causes.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store byte enables/replication, load extraction/extension,
// and the illegal/misaligned pre-checks. Zero latency, no flow control.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    input  logic        is_load,
    input  logic        is_store,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        illegal,
    output logic        misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        illegal = (is_load && is_store)
               || (is_load && (st_funct3 == 3'b011 || st_funct3 == 3'b110 || st_funct3 == 3'b111))
               || (is_store && (st_funct3 > 3'b010));
        misalign = ((st_funct3[1:0] == 2'b01) && st_addr_lo[0])
                || ((st_funct3[1:0] == 2'b10) && (st_addr_lo != 2'b00));

        be    = 4'b0000;
        wdata = st_data;
        case (st_funct3)
            SB: begin
                be    = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SH: begin
                be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            SW: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        // Loads always fetch the full word; the lane is picked on the way back.
        if (!is_store) be = 4'b1111;
    end

    always_comb begin
        shifted = ld_rdata >> {ld_addr_lo, 3'b000};
        case (ld_funct3)
            LB:      ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LW:      ld_data = shifted;
            LBU:     ld_data = {24'd0, shifted[7:0]};
            LHU:     ld_data = {16'd0, shifted[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one load/store per instruction over req/gnt/rvalid; min latency accept->wb_valid 3 cycles.
// Stalls upstream via lsu_busy whenever not IDLE; aborts with a timeout error if memory never answers.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        lsu_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_err,
    output logic [1:0]  lsu_err_cause
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_load;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [4:0]       rd_q;
    logic             flushed;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        illegal;
    logic        misalign;
    logic [31:0] ld_data;
    logic        accept;
    logic        timeout_hit;

    lsu_align u_align (
        .st_funct3  (ex_funct3),
        .st_addr_lo (ex_addr[1:0]),
        .st_data    (ex_store_data),
        .is_load    (ex_mem_read),
        .is_store   (ex_mem_write),
        .be         (st_be),
        .wdata      (st_wdata),
        .illegal    (illegal),
        .misalign   (misalign),
        .ld_funct3  (funct3_q),
        .ld_addr_lo (addr_lo_q),
        .ld_rdata   (mem_rdata),
        .ld_data    (ld_data)
    );

    assign accept      = ex_valid && (ex_mem_read || ex_mem_write) && !flush;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign lsu_busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            is_load       <= 1'b0;
            funct3_q      <= 3'd0;
            addr_lo_q     <= 2'd0;
            rd_q          <= 5'd0;
            flushed       <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_be        <= 4'd0;
            mem_wdata     <= 32'd0;
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'd0;
            lsu_err       <= 1'b0;
            lsu_err_cause <= ERR_NONE;
        end else begin
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            lsu_err       <= 1'b0;
            lsu_err_cause <= ERR_NONE;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            lsu_err       <= 1'b1;
                            lsu_err_cause <= ERR_ILLEGAL;
                        end else if (misalign) begin
                            lsu_err       <= 1'b1;
                            lsu_err_cause <= ERR_MISALIGN;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            flushed   <= 1'b0;
                            is_load   <= ex_mem_read;
                            funct3_q  <= ex_funct3;
                            addr_lo_q <= ex_addr[1:0];
                            rd_q      <= ex_rd;
                            mem_req   <= 1'b1;
                            mem_we    <= ex_mem_write;
                            mem_addr  <= {ex_addr[31:2], 2'b00};
                            mem_be    <= st_be;
                            mem_wdata <= st_wdata;
                        end
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        mem_req       <= 1'b0;
                        state         <= IDLE;
                        lsu_err       <= 1'b1;
                        lsu_err_cause <= ERR_TIMEOUT;
                    end else if (mem_gnt) begin
                        // A grant commits the access even if flushed this cycle.
                        mem_req <= 1'b0;
                        state   <= WAIT;
                        flushed <= flush;
                        cnt     <= cnt + 1'b1;
                    end else if (flush) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state    <= DONE;
                        wb_valid <= !(flushed || flush);
                        wb_we    <= is_load && (rd_q != 5'd0) && !(flushed || flush);
                        wb_rd    <= rd_q;
                        wb_data  <= is_load ? ld_data : 32'd0;
                    end else if (timeout_hit) begin
                        state         <= IDLE;
                        lsu_err       <= 1'b1;
                        lsu_err_cause <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (flush) flushed <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: expected write-backs and errors are queued at issue.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0, ex_store_data = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        flush = 1'b0;
    logic        lsu_busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid, wb_we, lsu_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  lsu_err_cause;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t    wb_q[$];
    logic [1:0] err_q[$];
    int vectors = 0;
    int miscompares = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .flush(flush), .lsu_busy(lsu_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_err(lsu_err), .lsu_err_cause(lsu_err_cause)
    );

    always #5 clk = ~clk;

    // Scoreboard pop side: every write-back and error pulse must have been predicted.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            vectors++;
            if (wb_q.size() == 0) begin
                miscompares++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write-back", wb_rd, wb_data);
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                if (wb_we !== e.we || wb_rd !== e.rd || wb_data !== e.data) begin
                    miscompares++;
                    $display("FAIL wb_result: got we=%b rd=%0d data=%h, expected we=%b rd=%0d data=%h",
                             wb_we, wb_rd, wb_data, e.we, e.rd, e.data);
                end
            end
        end
        if (rst_n && lsu_err) begin
            vectors++;
            if (err_q.size() == 0) begin
                miscompares++;
                $display("FAIL err_unexpected: got cause=%b, expected no error", lsu_err_cause);
            end else begin
                logic [1:0] c;
                c = err_q.pop_front();
                if (lsu_err_cause !== c) begin
                    miscompares++;
                    $display("FAIL err_cause: got %b, expected %b", lsu_err_cause, c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en;
        ex_funct3 = f3; ex_addr = addr; ex_store_data = data; ex_rd = rd;
        tick();
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    // Leaves the bench in the DONE cycle (the one where wb_valid should be high).
    task automatic mem_respond(input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        repeat (gnt_dly) tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (rv_dly) tick();
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0] b[4];
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        h = {b[(a + 2'd1) & 2'd3], b[a]};
        case (f3)
            LB:  return b[a][7] ? {24'hFFFFFF, b[a]} : {24'h0, b[a]};
            LBU: return {24'h0, b[a]};
            LH:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
            LHU: return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic test_reset();
        tick(); tick();
        vectors++;
        if ({lsu_busy, mem_req, mem_we, mem_be, wb_valid, wb_we, lsu_err, lsu_err_cause} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b req=%b be=%b wbv=%b err=%b, expected all 0",
                     lsu_busy, mem_req, mem_be, wb_valid, lsu_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store_byte();
        wb_q.push_back('{we: 1'b0, rd: 5'd3, data: 32'd0});
        issue(1'b0, 1'b1, SB, 32'h0000_1003, 32'h0000_00A5, 5'd3);
        vectors++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1000 ||
            mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h0000_1000 || lsu_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_request: got req=%b we=%b be=%b wdata=%h addr=%h, expected 1 1 1000 a5a5a5a5 00001000",
                     mem_req, mem_we, mem_be, mem_wdata, mem_addr);
        end
        mem_respond(1, 1, 32'hDEAD_BEEF);
        tick();
        vectors++;
        if (lsu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_idle: got busy=%b, expected 0", lsu_busy);
        end
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
        wb_q.push_back('{we: 1'b1, rd: 5'd5, data: exp});
        issue(1'b1, 1'b0, f3, 32'h0000_2001, 32'd0, 5'd5);
        vectors++;
        if (mem_req !== 1'b1 || mem_be !== 4'b1111 || mem_addr !== 32'h0000_2000) begin
            miscompares++;
            $display("FAIL lb_request: got req=%b be=%b addr=%h, expected 1 1111 00002000", mem_req, mem_be, mem_addr);
        end
        mem_respond(0, 0, 32'h0000_8000);
        vectors++;
        if (wb_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL lb_latency: got wb_valid=%b at T0+3, expected 1", wb_valid);
        end
        tick();
    endtask

    task automatic test_misalign();
        err_q.push_back(ERR_MISALIGN);
        issue(1'b1, 1'b0, LW, 32'h0000_3002, 32'd0, 5'd6);
        vectors++;
        if (lsu_err !== 1'b1 || mem_req !== 1'b0 || lsu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign: got err=%b req=%b busy=%b, expected 1 0 0", lsu_err, mem_req, lsu_busy);
        end
        tick();
    endtask

    task automatic test_illegal();
        err_q.push_back(ERR_ILLEGAL);
        issue(1'b1, 1'b1, LW, 32'h0000_0100, 32'd0, 5'd1);
        err_q.push_back(ERR_ILLEGAL);
        issue(1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'd0, 5'd1);
        vectors++;
        if (lsu_err !== 1'b1 || mem_req !== 1'b0 || lsu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal: got err=%b req=%b busy=%b, expected 1 0 0", lsu_err, mem_req, lsu_busy);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n = 0;
        err_q.push_back(ERR_TIMEOUT);
        issue(1'b1, 1'b0, LW, 32'h0000_5000, 32'd0, 5'd7);
        for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
            n++;
            tick();
        end
        vectors++;
        if (n != 16 || lsu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_req_cycles: got %0d cycles busy=%b, expected 16 cycles busy=0", n, lsu_busy);
        end
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        tick(); tick();
        vectors++;
        if (wb_valid !== 1'b0 || lsu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_rvalid: got wb_valid=%b busy=%b, expected 0 0", wb_valid, lsu_busy);
        end
    endtask

    task automatic test_load_half_rd0();
        wb_q.push_back('{we: 1'b0, rd: 5'd0, data: 32'h0000_7FFF});
        issue(1'b1, 1'b0, LH, 32'h0000_4002, 32'd0, 5'd0);
        mem_respond(0, 1, 32'h7FFF_0000);
        tick();
    endtask

    task automatic test_flush();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = LW; ex_addr = 32'h0000_6000; flush = 1'b1;
        tick();
        ex_valid = 1'b0; ex_mem_read = 1'b0; flush = 1'b0;
        vectors++;
        if (lsu_busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: got busy=%b req=%b, expected 0 0", lsu_busy, mem_req);
        end
        issue(1'b1, 1'b0, LW, 32'h0000_6000, 32'd0, 5'd8);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++;
        if (mem_req !== 1'b0 || lsu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_req: got req=%b busy=%b, expected 0 0", mem_req, lsu_busy);
        end
        tick(); tick();
        issue(1'b1, 1'b0, LW, 32'h0000_6004, 32'd0, 5'd9);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        vectors++;
        if (wb_valid !== 1'b0 || lsu_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_wait_done: got wb_valid=%b busy=%b, expected 0 1", wb_valid, lsu_busy);
        end
        tick();
        vectors++;
        if (lsu_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_wait_idle: got busy=%b, expected 0", lsu_busy);
        end
    endtask

    task automatic test_reset_mid_access();
        issue(1'b1, 1'b0, LW, 32'h0000_7000, 32'd0, 5'd10);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (lsu_busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b req=%b, expected 0 0", lsu_busy, mem_req);
        end
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3s[5];
        f3s = '{LB, LH, LW, LBU, LHU};
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  f3;
            logic [1:0]  a;
            logic [31:0] w;
            logic [4:0]  rd;
            f3 = f3s[$urandom_range(0, 4)];
            a  = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a = 2'b00;
            w  = $urandom;
            rd = 5'($urandom_range(0, 31));
            wb_q.push_back('{we: (rd != 5'd0), rd: rd, data: load_model(f3, a, w)});
            issue(1'b1, 1'b0, f3, {20'h0_8000, 4'(i), 6'd0, a}, 32'd0, rd);
            mem_respond($urandom_range(0, 2), $urandom_range(0, 2), w);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_byte(LB, 32'hFFFF_FF80);
        test_load_byte(LBU, 32'h0000_0080);
        test_misalign();
        test_illegal();
        test_timeout();
        test_load_half_rd0();
        test_flush();
        test_reset_mid_access();
        test_back_to_back();
        tick(); tick();
        vectors++;
        if (wb_q.size() != 0 || err_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d wb and %0d err pending, expected 0 and 0",
                     wb_q.size(), err_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage block directly downstream of the ALU. It takes the ALU result as the effective address and performs one load or store per instruction over a req/gnt/rvalid data-memory handshake. Byte-lane placement, load sign/zero extension, misalignment detection and access timeout are all handled here. While an access is in flight it stalls the pipeline, and it hands load results to write-back.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in REQ+WAIT before the access is aborted with a timeout error (minimum 2)
CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  upstream instruction valid
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store
ex_funct3  in  3  RV32I width/sign code
ex_addr  in  32  effective address (ALU alu_out)
ex_store_data  in  32  rs2 value
ex_rd  in  5  load destination register
flush  in  1  pipeline flush
lsu_busy  out  1  stall request to the pipeline
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  response valid (loads and stores)
mem_rdata  in  32  read word
wb_valid  out  1  one-cycle pulse: access completed
wb_we  out  1  register write (load with rd != 0)
wb_rd  out  5  destination register
wb_data  out  32  extended load data (0 for stores)
lsu_err  out  1  one-cycle error pulse
lsu_err_cause  out  2  01 misaligned, 10 timeout, 11 illegal

Behaviour:
- Clocking and reset: single clock clk; reset is asynchronous, active-low on rst_n.
- Reset forces state IDLE and counter 0. All outputs are 0, including lsu_busy, mem_req, mem_be, wb_* and lsu_err*.
- Reset asserted mid-access abandons the access immediately. Nothing is replayed.
- FSM states:
  - IDLE:
    - Accept when ex_valid & (ex_mem_read | ex_mem_write) & !flush.
    - Capture addr, funct3, rd, direction and the aligned store data/byte enables.
    - Go to REQ.
  - REQ:
    - mem_req=1, with mem_we/addr/be/wdata held stable until granted.
    - On mem_gnt, go to WAIT.
  - WAIT:
    - mem_req=0.
    - On mem_rvalid: register wb_* from mem_rdata, go to DONE.
  - DONE:
    - wb_valid=1 for exactly one cycle, then go to IDLE.
- lsu_busy = (state != IDLE). Upstream holds its ex_* inputs while busy. ex_valid is ignored unless the state is IDLE.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the following cycle:
  - Accept edge is T0.
  - mem_req high in cycle T0+1.
  - rvalid arrives in T0+2.
  - wb_valid high in T0+3.
- mem_rvalid seen in REQ or IDLE is ignored. This covers late responses after a timeout or reset.
- Pre-checks are evaluated on the accept cycle. A failing check produces no memory access: a 1-cycle lsu_err pulse on the next cycle, state stays IDLE, wb_valid is never raised. Checks in priority order:
  1. Illegal (cause 11): ex_mem_read & ex_mem_write both set; or load funct3 in {011,110,111}; or store funct3 > 010.
  2. Misaligned (cause 01): half access with addr[0]=1; word access with addr[1:0]!=0.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=0011 when addr[1]=0, else 1100; wdata={2{half}}.
  - SW: be=1111.
- Loads drive mem_be=1111.
- Load extract: the lane is selected by addr[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- wb_we = load & (rd != 0).
- Timeout:
  - The counter clears on accept and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, pulse lsu_err with cause 10, go to IDLE, no wb_valid.
- Flush:
  - In IDLE, it blocks acceptance.
  - In REQ before gnt, the request is withdrawn and the FSM returns to IDLE silently.
  - In REQ on the same cycle as gnt, the access is committed and the FSM moves to WAIT.
  - In WAIT, the access completes; a flag suppresses wb_valid/wb_we in DONE.
- Simultaneous rvalid and timeout in the same cycle: rvalid wins.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encoding: IDLE, REQ, WAIT, DONE.
  - Error cause codes: ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL.
- One combinational sub-module, lsu_align, owns all lane logic: store byte enables and replication, load extraction and extension, and the misalign/illegal checks.

Test Plan:
- SB: addr=0x1003, data=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000; wb_valid after rvalid; wb_we=0.
- LB: addr=0x2001, rdata=0x0000_8000, rd=5 -> wb_data=0xFFFFFF80, wb_we=1, wb_valid at T0+3 with gnt and rvalid at minimum timing. Same access as LBU -> wb_data=0x00000080.
- LW: addr=0x3002 -> lsu_err=1 with cause 01 one cycle later; mem_req never asserted; lsu_busy stays 0.
- Load issued with gnt never returned, TIMEOUT_CYCLES=16 -> mem_req drops after 16 cycles, lsu_err with cause 10; a later stray rvalid produces no wb_valid.
- LH: rd=0, addr=0x4002, rdata=0x7FFF_0000 -> wb_data=0x00007FFF, wb_valid=1, wb_we=0.
- Flush in REQ before gnt -> mem_req drops next cycle, no wb_valid. Flush in WAIT -> rvalid consumed, wb_valid stays 0, lsu_busy falls.
